// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA push port and STATUS register in
// front of a small circular byte FIFO feeding an 8N1 serial framer.
module mmio_uart_tx #(
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] TXDATA_ADDR = 32'(BASE_ADDR);
  localparam logic [31:0] STATUS_ADDR = 32'(BASE_ADDR + 4);
  localparam logic [4:0]  DEPTH_CNT   = 5'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [15:0]      bit_timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             overflow;

  logic fifo_full;
  logic fifo_empty;
  logic fsm_active;
  logic wr_hit;
  logic clr_hit;
  logic push;
  logic pop;
  logic bit_done;
  logic unused_data;

  assign unused_data = ^data_out[31:8];

  always_comb begin
    fifo_full  = (count == DEPTH_CNT);
    fifo_empty = (count == '0);
    fsm_active = (state != IDLE);
    wr_hit     = mem_en && !mem_read && (addr == TXDATA_ADDR);
    clr_hit    = mem_en && !mem_read && (addr == STATUS_ADDR);
    push       = wr_hit && !fifo_full;
    pop        = (state == IDLE) && !fifo_empty;
    bit_done   = (bit_timer == BIT_LAST);
    busy       = fsm_active || !fifo_empty;
  end

  always_comb begin
    data_in = '0;
    if (mem_en && mem_read && (addr == STATUS_ADDR))
      data_in = {23'b0, count, overflow, fsm_active, fifo_empty, fifo_full};
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= data_out[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Fullness is judged on the registered count, so a same-cycle pop
      // does not rescue a write that arrives while full.
      if (wr_hit && fifo_full)
        overflow <= 1'b1;
      else if (clr_hit)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      bit_timer <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= fifo_mem[rd_ptr];
            tx        <= 1'b0;
            bit_timer <= '0;
            bit_idx   <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_timer <= '0;
            tx        <= shreg[0];
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_timer <= '0;
            state     <= IDLE;
          end else begin
            bit_timer <= bit_timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames and
// STATUS reads; a serial receiver and a read monitor pop and compare.
module tb_mmio_uart_tx;

  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_en  (mem_en),
    .mem_read(mem_read),
    .addr    (addr),
    .data_out(data_out),
    .data_in (data_in),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t      exp_q[$];
  logic [31:0] rd_q[$];

  logic [7:0] c_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] d_bytes [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_frame(input logic [7:0] d, input int s);
    frame_t f;
    f.data  = d;
    f.start = s;
    exp_q.push_back(f);
  endfunction

  // Bus tasks are entered 1 time unit after a posedge and return likewise.
  task automatic wr(input logic [31:0] a, input logic [7:0] d, output int n);
    n        = cyc + 1;
    mem_en   = 1'b1;
    mem_read = 1'b0;
    addr     = a;
    data_out = {24'hA5C3E1, d};
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic en, input logic [31:0] e);
    rd_q.push_back(e);
    mem_en   = en;
    mem_read = 1'b1;
    addr     = a;
    data_out = '0;
    @(posedge clk); #1;
  endtask

  task automatic idle_bus;
    mem_en   = 1'b0;
    mem_read = 1'b0;
    addr     = '0;
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int t);
    mem_en   = 1'b0;
    mem_read = 1'b0;
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle;
    int n;
    n        = 0;
    mem_en   = 1'b0;
    mem_read = 1'b0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  // Read monitor: data_in is combinational, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_read === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", data_in);
      end else begin
        check("rd_data", data_in, rd_q.pop_front());
      end
    end
  end

  // Serial receiver: one sample per cycle, 40 samples per 8N1 frame.
  logic       rx_on = 1'b0;
  int         rx_k;
  int         rx_start;
  int         rx_bi;
  logic [7:0] rx_byte;
  logic       rx_ok;
  frame_t     rx_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on    = 1'b1;
        rx_k     = 1;
        rx_start = cyc;
        rx_ok    = 1'b1;
        rx_byte  = '0;
      end
    end else begin
      if (rx_k < 4) begin
        if (tx !== 1'b0) rx_ok = 1'b0;
      end else if (rx_k < 36) begin
        rx_bi = (rx_k - 4) / 4;
        if ((rx_k - 4) % 4 == 0) rx_byte[rx_bi] = tx;
        else if (tx !== rx_byte[rx_bi]) rx_ok = 1'b0;
      end else if (tx !== 1'b1) begin
        rx_ok = 1'b0;
      end
      rx_k++;
      if (rx_k == 40) begin
        rx_on = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got 0x%0h expected no frame", rx_byte);
        end else begin
          rx_exp = exp_q.pop_front();
          check("frame_data", {24'b0, rx_byte}, {24'b0, rx_exp.data});
          check("frame_shape", {31'b0, rx_ok}, 32'h1);
          check("frame_start", rx_start, rx_exp.start);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    int m;
    int tmp;
    rst_n    = 1'b0;
    mem_en   = 1'b0;
    mem_read = 1'b0;
    addr     = '0;
    data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;

    // Decode: STATUS from reset, TXDATA reads, unmapped, and mem_en low.
    rd(BASE + 4, 1'b1, 32'h002);
    rd(BASE,     1'b1, 32'h000);
    rd(2048,     1'b1, 32'h000);
    rd(BASE + 4, 1'b0, 32'h000);

    // Single frame, latency and busy timing.
    wr(BASE, 8'h41, n);
    expect_frame(8'h41, n + 1);
    rd(BASE + 4, 1'b1, 32'h010);
    rd(BASE + 4, 1'b1, 32'h006);
    wait_until(n + 40);
    check("busy_in_stop", {31'b0, busy}, 32'h1);
    wait_until(n + 41);
    check("busy_after_frame", {31'b0, busy}, 32'h0);

    // Five back-to-back writes from idle: all accepted.
    wait_idle();
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      wr(BASE, c_bytes[i], n);
      if (i == 0) n0 = n;
      expect_frame(c_bytes[i], n0 + 1 + 41 * i);
    end
    rd(BASE + 4, 1'b1, 32'h045);
    wait_idle();

    // Five writes while a frame is running: the fifth overflows.
    wr(BASE, 8'h5A, n);
    expect_frame(8'h5A, n + 1);
    idle_bus();
    idle_bus();
    for (int i = 0; i < 5; i++) begin
      wr(BASE, d_bytes[i], m);
      if (i < 4) expect_frame(d_bytes[i], n + 42 + 41 * i);
    end
    rd(BASE + 4, 1'b1, 32'h04D);
    wr(BASE + 4, 8'hFF, tmp);
    rd(BASE + 4, 1'b1, 32'h045);
    // Write while full on the same edge as the pop: still dropped.
    wait_until(n + 41);
    wr(BASE, 8'hEE, tmp);
    rd(BASE + 4, 1'b1, 32'h03C);
    wr(BASE + 4, 8'h00, tmp);
    wait_idle();
    rd(BASE + 4, 1'b1, 32'h002);

    // Reset mid-DATA of 0x00 with 0x77 queued behind it.
    wr(BASE, 8'h00, n);
    wr(BASE, 8'h77, tmp);
    wait_until(n + 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'h1);
    check("async_reset_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(BASE, 8'h3C, n);
    expect_frame(8'h3C, n + 1);
    rd(BASE + 4, 1'b1, 32'h010);
    wait_idle();

    idle_bus();
    check("frames_pending", exp_q.size(), 32'h0);
    check("reads_pending", rd_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
